// File: rtl/pipe_ctrl_unit.sv
// Pipelined ARM control unit: decode, E/M/W control pipeline, NZCV flags and condition check.
// Optional performance counters (RetireCnt, CondFailCnt) are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl_unit #(
    parameter int MEM_LAT  = 1,
    parameter int ALUCTL_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         InstrD,
    input  logic [3:0]          ALUFlagsE,
    input  logic                FlushE,
    output logic [1:0]          RegSrcD,
    output logic [1:0]          ImmSrcD,
    output logic                ALUSrcE,
    output logic [ALUCTL_W-1:0] ALUControlE,
    output logic                MemtoRegE,
    output logic                BranchTakenE,
    output logic                RegWriteM,
    output logic                MemWriteM,
    output logic                RegWriteW,
    output logic                MemtoRegW,
    output logic                PCSrcW,
    output logic                PCWrPendingF,
    output logic [3:0]          FlagsOut
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]         RetireCnt,
    output logic [31:0]         CondFailCnt
`endif
);

    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic [3:0] cond_d;

    assign op     = InstrD[27:26];
    assign funct  = InstrD[25:20];
    assign cmd    = funct[4:1];
    assign cond_d = InstrD[31:28];

    logic [1:0] regsrc_d, immsrc_d, flagw_d;
    logic       alusrc_d, regw_d, memw_d, memtoreg_d, branch_d, pcs_d;
    logic [2:0] aluctl3_d;
    logic       cmd_known, no_write, arith_cmd;

    always_comb begin
        regsrc_d   = 2'b00;
        immsrc_d   = 2'b00;
        flagw_d    = 2'b00;
        alusrc_d   = 1'b0;
        regw_d     = 1'b0;
        memw_d     = 1'b0;
        memtoreg_d = 1'b0;
        branch_d   = 1'b0;
        aluctl3_d  = 3'b000;
        cmd_known  = 1'b0;
        no_write   = 1'b0;
        arith_cmd  = 1'b0;
        case (op)
            2'b00: begin
                alusrc_d = funct[5];
                case (cmd)
                    4'b0000: begin aluctl3_d = 3'b010; cmd_known = 1'b1; end
                    4'b1100: begin aluctl3_d = 3'b011; cmd_known = 1'b1; end
                    4'b0100: begin aluctl3_d = 3'b000; cmd_known = 1'b1; arith_cmd = 1'b1; end
                    4'b0010: begin aluctl3_d = 3'b001; cmd_known = 1'b1; arith_cmd = 1'b1; end
                    4'b0001: begin aluctl3_d = 3'b100; cmd_known = 1'b1; end
                    4'b1101: begin aluctl3_d = 3'b101; cmd_known = 1'b1; end
                    4'b1010: begin aluctl3_d = 3'b001; cmd_known = 1'b1; arith_cmd = 1'b1; no_write = 1'b1; end
                    4'b1011: begin aluctl3_d = 3'b000; cmd_known = 1'b1; arith_cmd = 1'b1; no_write = 1'b1; end
                    4'b1000: begin aluctl3_d = 3'b010; cmd_known = 1'b1; no_write = 1'b1; end
                    default: aluctl3_d = 3'b000;
                endcase
                regw_d  = cmd_known & ~no_write;
                flagw_d = cmd_known ? {funct[0], funct[0] & arith_cmd} : 2'b00;
            end
            2'b01: begin
                alusrc_d = 1'b1;
                immsrc_d = 2'b01;
                if (funct[0]) begin
                    regw_d     = 1'b1;
                    memtoreg_d = 1'b1;
                end else begin
                    regsrc_d = 2'b10;
                    memw_d   = 1'b1;
                end
            end
            2'b10: begin
                regsrc_d = 2'b01;
                immsrc_d = 2'b10;
                alusrc_d = 1'b1;
                branch_d = 1'b1;
            end
            default: regsrc_d = 2'b00;
        endcase
    end

    assign pcs_d   = ((InstrD[15:12] == 4'hF) & regw_d) | branch_d;
    assign RegSrcD = regsrc_d;
    assign ImmSrcD = immsrc_d;

    logic                e_valid, e_regw, e_memw, e_memtoreg, e_alusrc, e_branch, e_pcs;
    logic [3:0]          e_cond;
    logic [1:0]          e_flagw;
    logic [ALUCTL_W-1:0] e_aluctl;

    // A flushed instruction enters E as an all-zero bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || FlushE) begin
            e_valid    <= 1'b0;
            e_regw     <= 1'b0;
            e_memw     <= 1'b0;
            e_memtoreg <= 1'b0;
            e_alusrc   <= 1'b0;
            e_branch   <= 1'b0;
            e_pcs      <= 1'b0;
            e_cond     <= 4'h0;
            e_flagw    <= 2'b00;
            e_aluctl   <= '0;
        end else begin
            e_valid    <= 1'b1;
            e_regw     <= regw_d;
            e_memw     <= memw_d;
            e_memtoreg <= memtoreg_d;
            e_alusrc   <= alusrc_d;
            e_branch   <= branch_d;
            e_pcs      <= pcs_d;
            e_cond     <= cond_d;
            e_flagw    <= flagw_d;
            e_aluctl   <= ALUCTL_W'(aluctl3_d);
        end
    end

    logic condex, e_exec;
    logic fn, fz, fc, fv;
    assign {fn, fz, fc, fv} = FlagsOut;

    always_comb begin
        condex = 1'b0;
        case (e_cond)
            4'h0: condex = fz;
            4'h1: condex = ~fz;
            4'h2: condex = fc;
            4'h3: condex = ~fc;
            4'h4: condex = fn;
            4'h5: condex = ~fn;
            4'h6: condex = fv;
            4'h7: condex = ~fv;
            4'h8: condex = fc & ~fz;
            4'h9: condex = ~fc | fz;
            4'hA: condex = (fn == fv);
            4'hB: condex = (fn != fv);
            4'hC: condex = ~fz & (fn == fv);
            4'hD: condex = fz | (fn != fv);
            4'hE: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    assign e_exec = e_valid & condex;

    logic [MEM_LAT-1:0] m_regw, m_memw, m_memtoreg, m_pcs, m_exec;
    logic               w_regw, w_memtoreg, w_pcs, w_exec;

    // Write enables are squashed here, so every later stage only sees executed effects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_regw     <= '0;
            m_memw     <= '0;
            m_memtoreg <= '0;
            m_pcs      <= '0;
            m_exec     <= '0;
            w_regw     <= 1'b0;
            w_memtoreg <= 1'b0;
            w_pcs      <= 1'b0;
            w_exec     <= 1'b0;
        end else begin
            m_regw[0]     <= e_regw & e_exec;
            m_memw[0]     <= e_memw & e_exec;
            m_memtoreg[0] <= e_memtoreg;
            m_pcs[0]      <= e_pcs & e_exec;
            m_exec[0]     <= e_exec;
            for (int i = 1; i < MEM_LAT; i++) begin
                m_regw[i]     <= m_regw[i-1];
                m_memw[i]     <= m_memw[i-1];
                m_memtoreg[i] <= m_memtoreg[i-1];
                m_pcs[i]      <= m_pcs[i-1];
                m_exec[i]     <= m_exec[i-1];
            end
            w_regw     <= m_regw[MEM_LAT-1];
            w_memtoreg <= m_memtoreg[MEM_LAT-1];
            w_pcs      <= m_pcs[MEM_LAT-1];
            w_exec     <= m_exec[MEM_LAT-1];
        end
    end

    // Flags update as the setter leaves E, so its successor sees them immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            FlagsOut <= 4'h0;
        end else if (e_exec) begin
            if (e_flagw[1]) FlagsOut[3:2] <= ALUFlagsE[3:2];
            if (e_flagw[0]) FlagsOut[1:0] <= ALUFlagsE[1:0];
        end
    end

    assign ALUSrcE      = e_alusrc;
    assign ALUControlE  = e_aluctl;
    assign MemtoRegE    = e_memtoreg;
    assign BranchTakenE = e_branch & e_exec;
    assign RegWriteM    = m_regw[0];
    assign MemWriteM    = m_memw[0];
    assign RegWriteW    = w_regw;
    assign MemtoRegW    = w_memtoreg;
    assign PCSrcW       = w_pcs;
    assign PCWrPendingF = pcs_d | (e_pcs & e_exec) | (|m_pcs);

    logic unused_bits;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RetireCnt   <= 32'd0;
            CondFailCnt <= 32'd0;
        end else begin
            if (w_exec) RetireCnt <= RetireCnt + 32'd1;
            if (e_valid && !condex) CondFailCnt <= CondFailCnt + 32'd1;
        end
    end
    assign unused_bits = ^{InstrD[19:16], InstrD[11:0]};
`else
    assign unused_bits = ^{InstrD[19:16], InstrD[11:0], w_exec};
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: directed program plus random instructions checked
// against an instruction-level model. Define PIPE_CTRL_PERF_EN to also check the counters.
module tb_pipe_ctrl_unit;

    localparam int MEM_LAT = 1;
    localparam int LAST    = MEM_LAT + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] InstrD = 32'h0;
    logic [3:0]  ALUFlagsE = 4'h0;
    logic        FlushE = 1'b0;
    logic [1:0]  RegSrcD, ImmSrcD;
    logic        ALUSrcE, MemtoRegE, BranchTakenE, RegWriteM, MemWriteM;
    logic        RegWriteW, MemtoRegW, PCSrcW, PCWrPendingF;
    logic [3:0]  ALUControlE, FlagsOut;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] RetireCnt, CondFailCnt;
`endif

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.MEM_LAT(MEM_LAT), .ALUCTL_W(4)) dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .ALUFlagsE(ALUFlagsE), .FlushE(FlushE),
        .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .PCSrcW(PCSrcW), .PCWrPendingF(PCWrPendingF), .FlagsOut(FlagsOut)
`ifdef PIPE_CTRL_PERF_EN
        , .RetireCnt(RetireCnt), .CondFailCnt(CondFailCnt)
`endif
    );

    typedef struct packed {
        logic       valid, exec, regw, memw, memtoreg, alusrc, branch, pcs;
        logic [1:0] flagw, regsrc, immsrc;
        logic [3:0] aluctl, cond;
    } ctl_t;

    typedef struct packed {
        logic [1:0]  regsrc, immsrc;
        logic        alusrc;
        logic [3:0]  aluctl;
        logic        memtoregE, btaken, regwM, memwM, regwW, memtoregW, pcsrcW, pending;
        logic [3:0]  flags;
        logic [31:0] retire, cfail;
    } exp_t;

    exp_t        expq[$];
    ctl_t        pipe [0:LAST];
    logic [3:0]  mflags;
    logic [31:0] mretire, mcfail;
    int          checks = 0;
    int          errors = 0;

    function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
        bit n = f[3], z = f[2], cy = f[1], v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction-level decode taken straight from the ARM control table.
    function automatic ctl_t model_decode(logic [31:0] ins);
        ctl_t       c = '0;
        logic [3:0] cmd = ins[24:21];
        bit         s = ins[20];
        c.valid = 1'b1;
        c.cond  = ins[31:28];
        case (ins[27:26])
            2'b00: begin
                c.alusrc = ins[25];
                case (cmd)
                    4'b0000: begin c.aluctl = 4'd2; c.regw = 1; c.flagw = {s, 1'b0}; end
                    4'b1100: begin c.aluctl = 4'd3; c.regw = 1; c.flagw = {s, 1'b0}; end
                    4'b0100: begin c.aluctl = 4'd0; c.regw = 1; c.flagw = {s, s}; end
                    4'b0010: begin c.aluctl = 4'd1; c.regw = 1; c.flagw = {s, s}; end
                    4'b0001: begin c.aluctl = 4'd4; c.regw = 1; c.flagw = {s, 1'b0}; end
                    4'b1101: begin c.aluctl = 4'd5; c.regw = 1; c.flagw = {s, 1'b0}; end
                    4'b1010: begin c.aluctl = 4'd1; c.flagw = {s, s}; end
                    4'b1011: begin c.aluctl = 4'd0; c.flagw = {s, s}; end
                    4'b1000: begin c.aluctl = 4'd2; c.flagw = {s, 1'b0}; end
                    default: c.aluctl = 4'd0;
                endcase
            end
            2'b01: begin
                c.alusrc = 1; c.immsrc = 2'b01;
                if (ins[20]) begin c.regw = 1; c.memtoreg = 1; end
                else         begin c.regsrc = 2'b10; c.memw = 1; end
            end
            2'b10: begin c.regsrc = 2'b01; c.immsrc = 2'b10; c.alusrc = 1; c.branch = 1; end
            default: c.valid = 1'b1;
        endcase
        c.pcs = (ins[15:12] == 4'hF && c.regw) || c.branch;
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i <= LAST; i++) pipe[i] = '0;
        mflags = 4'h0; mretire = 0; mcfail = 0;
    endtask

    // One clock edge of the whole machine, expressed per instruction.
    task automatic model_edge(logic [31:0] ins, bit flush, logic [3:0] af, bit rst);
        ctl_t e;
        bit   ex;
        if (rst) begin
            model_clear();
            return;
        end
        e  = pipe[0];
        ex = e.valid && cond_ok(e.cond, mflags);
        if (pipe[LAST].exec) mretire++;
        if (e.valid && !ex) mcfail++;
        if (ex && e.flagw[1]) mflags[3:2] = af[3:2];
        if (ex && e.flagw[0]) mflags[1:0] = af[1:0];
        e.exec = ex;
        e.regw = e.regw && ex;
        e.memw = e.memw && ex;
        e.pcs  = e.pcs && ex;
        for (int i = LAST; i >= 2; i--) pipe[i] = pipe[i-1];
        pipe[1] = e;
        pipe[0] = flush ? '0 : model_decode(ins);
    endtask

    function automatic exp_t build_exp(logic [31:0] ins);
        exp_t x;
        ctl_t d = model_decode(ins);
        bit   eok = pipe[0].valid && cond_ok(pipe[0].cond, mflags);
        x.regsrc    = d.regsrc;
        x.immsrc    = d.immsrc;
        x.alusrc    = pipe[0].alusrc;
        x.aluctl    = pipe[0].aluctl;
        x.memtoregE = pipe[0].memtoreg;
        x.btaken    = pipe[0].branch && eok;
        x.regwM     = pipe[1].regw;
        x.memwM     = pipe[1].memw;
        x.regwW     = pipe[LAST].regw;
        x.memtoregW = pipe[LAST].memtoreg;
        x.pcsrcW    = pipe[LAST].pcs;
        x.pending   = d.pcs || (pipe[0].pcs && eok);
        for (int i = 1; i <= MEM_LAT; i++) x.pending = x.pending || pipe[i].pcs;
        x.flags  = mflags;
        x.retire = mretire;
        x.cfail  = mcfail;
        return x;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    task automatic applyStimulus(logic [31:0] ins, bit flush, logic [3:0] af, bit rst);
        @(negedge clk);
        reset     = rst;
        InstrD    = ins;
        FlushE    = flush;
        ALUFlagsE = af;
        model_edge(ins, flush, af, rst);
        expq.push_back(build_exp(ins));
    endtask

    // Monitor: one expected record per cycle, compared just after the edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                x = expq.pop_front();
                checkOutput("RegSrcD", 32'(RegSrcD), 32'(x.regsrc));
                checkOutput("ImmSrcD", 32'(ImmSrcD), 32'(x.immsrc));
                checkOutput("ALUSrcE", 32'(ALUSrcE), 32'(x.alusrc));
                checkOutput("ALUControlE", 32'(ALUControlE), 32'(x.aluctl));
                checkOutput("MemtoRegE", 32'(MemtoRegE), 32'(x.memtoregE));
                checkOutput("BranchTakenE", 32'(BranchTakenE), 32'(x.btaken));
                checkOutput("RegWriteM", 32'(RegWriteM), 32'(x.regwM));
                checkOutput("MemWriteM", 32'(MemWriteM), 32'(x.memwM));
                checkOutput("RegWriteW", 32'(RegWriteW), 32'(x.regwW));
                checkOutput("MemtoRegW", 32'(MemtoRegW), 32'(x.memtoregW));
                checkOutput("PCSrcW", 32'(PCSrcW), 32'(x.pcsrcW));
                checkOutput("PCWrPendingF", 32'(PCWrPendingF), 32'(x.pending));
                checkOutput("FlagsOut", 32'(FlagsOut), 32'(x.flags));
`ifdef PIPE_CTRL_PERF_EN
                checkOutput("RetireCnt", RetireCnt, x.retire);
                checkOutput("CondFailCnt", CondFailCnt, x.cfail);
`endif
            end
        end
    end

    typedef struct packed {
        logic [31:0] ins;
        logic        flush;
        logic [3:0]  af;
        logic        rst;
    } step_t;

    localparam logic [31:0] NOPI = 32'hE1A00000;

    step_t prog[] = '{
        '{32'hE2821003, 1'b0, 4'h0, 1'b1},
        '{32'hE2821003, 1'b0, 4'h0, 1'b0},
        '{NOPI,         1'b0, 4'h0, 1'b1},
        '{NOPI,         1'b0, 4'h0, 1'b0},
        '{32'hE2821003, 1'b0, 4'h0, 1'b0},
        '{NOPI,         1'b0, 4'h0, 1'b0},
        '{NOPI,         1'b0, 4'h0, 1'b0},
        '{NOPI,         1'b0, 4'h0, 1'b0},
        '{32'hE2522001, 1'b0, 4'h0, 1'b0},
        '{32'h0A000002, 1'b0, 4'h4, 1'b0},
        '{NOPI,         1'b0, 4'h0, 1'b0},
        '{NOPI,         1'b0, 4'h0, 1'b0},
        '{32'hE2522001, 1'b0, 4'h0, 1'b0},
        '{32'h0A000002, 1'b0, 4'h0, 1'b0},
        '{NOPI,         1'b0, 4'h0, 1'b0},
        '{NOPI,         1'b0, 4'h0, 1'b0},
        '{32'hE5801000, 1'b0, 4'h0, 1'b0},
        '{NOPI,         1'b0, 4'h0, 1'b0},
        '{32'hE2821003, 1'b1, 4'h0, 1'b0},
        '{NOPI,         1'b0, 4'h0, 1'b0},
        '{NOPI,         1'b0, 4'h0, 1'b0},
        '{32'hE2522001, 1'b0, 4'h0, 1'b0},
        '{32'h12821003, 1'b0, 4'h4, 1'b0},
        '{32'hF2821003, 1'b0, 4'h0, 1'b0},
        '{32'hE281F003, 1'b0, 4'h0, 1'b0},
        '{NOPI,         1'b0, 4'h0, 1'b0},
        '{NOPI,         1'b0, 4'h0, 1'b0},
        '{NOPI,         1'b0, 4'h0, 1'b0}
    };

    initial begin
        logic [31:0] ins;
        int          waits;
        model_clear();
        repeat (2) @(posedge clk);
        foreach (prog[i]) applyStimulus(prog[i].ins, prog[i].flush, prog[i].af, prog[i].rst);
        for (int n = 0; n < 600; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 1) == 0) ins[31:28] = 4'hE;
            if ($urandom_range(0, 7) == 0) ins[15:12] = 4'hF;
            applyStimulus(ins, $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 59) == 0);
        end
        waits = 0;
        while (expq.size() > 0 && waits < 10) begin
            @(posedge clk);
            waits++;
        end
        #2;
        checkOutput("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Pipelined ARM control unit, successor to the single-stage decoder. Decodes the instruction in Decode, carries control through E, MEM_LAT memory slots and W, and evaluates all 15 ARM condition codes against an internal NZCV register. It also produces branch-taken, PC-write-pending and bubble handling for the hazard unit. It sits between instruction fetch/hazard logic and the datapath.

Parameters:
MEM_LAT, 1, number of memory-stage register slots between E and W (legal 1..4)
ALUCTL_W, 4, width of ALUControl (minimum 3)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
InstrD  in  32  instruction in Decode: [31:28] cond, [27:26] Op, [25:20] Funct, [15:12] Rd
ALUFlagsE  in  4  NZCV from the ALU for the instruction in E
FlushE  in  1  turns the instruction entering E into a bubble
RegSrcD  out  2  register-read source select (combinational, Decode)
ImmSrcD  out  2  extend mode (combinational, Decode)
ALUSrcE  out  1  1 = immediate operand B
ALUControlE  out  ALUCTL_W  ALU operation
MemtoRegE  out  1  load in E, for load-use detection
BranchTakenE  out  1  taken branch in E
RegWriteM  out  1  register write in the first M slot, for forwarding
MemWriteM  out  1  memory write enable, first M slot
RegWriteW  out  1  register write enable in W
MemtoRegW  out  1  1 = result comes from memory
PCSrcW  out  1  PC written from the result in W
PCWrPendingF  out  1  a PC write is in flight in D, E or any M slot
FlagsOut  out  4  architectural NZCV register

Behaviour:
- Decode, combinational:
  - Op=00 data processing. Funct[5]=I selects ALUSrc; RegSrc=00; ImmSrc=00.
  - Funct[4:1] to ALUControl: AND 0000->0010, ORR 1100->0011, ADD 0100->0000, SUB 0010->0001, EOR 0001->0100, MOV 1101->0101, CMP 1010->0001, CMN 1011->0000, TST 1000->0010.
  - CMP, CMN and TST set NoWrite, which forces RegW=0.
  - Any other cmd decodes as a NOP: RegW=0, FlagW=00.
  - FlagW[1]=S. FlagW[0]=S and the cmd is ADD, SUB, CMP or CMN.
- Op=01 memory. Funct[0]=L. ALUSrc=1, ImmSrc=01.
  - LDR: RegSrc=00, RegW=1, MemtoReg=1.
  - STR: RegSrc=10, MemW=1.
- Op=10 branch: RegSrc=01, ImmSrc=10, ALUSrc=1, Branch=1.
- Op=11 is a safe NOP: all write enables 0 and defined zero outputs (never X).
- PCS = (Rd==15 and RegW) or Branch.
- Pipeline:
  - D->E register captures the decoded controls, cond and valid=1.
  - When FlushE=1 at an edge, E captures all zeros (valid=0).
  - E->M1->...->M[MEM_LAT]->W are plain shift registers with no stall.
  - Latency from D to W is MEM_LAT+2 edges.
- Condition check in E:
  - CondExE is evaluated from the current FlagsOut, not ALUFlagsE.
  - Codes: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL.
  - cond=1111 never executes.
  - If CondExE=0, RegWrite, MemWrite and PCS are cleared before entering M1.
- Flags: at an edge where E is valid and CondExE=1:
  - FlagW[1] loads N,Z from ALUFlagsE[3:2].
  - FlagW[0] loads C,V from ALUFlagsE[1:0].
  - The instruction immediately following a flag-setter sees the updated flags, with no bypass gap.
- BranchTakenE = valid and Branch and CondExE.
- PCSrcW = PCS carried into W, already gated by CondExE.
- PCWrPendingF = PCSD or PCSE or any M-slot PCS. The E and M terms use the gated values.
- Reset, at any time including mid-pipeline:
  - All stage registers, valid bits and FlagsOut go to 0.
  - All registered outputs read 0 while reset is high and on the first cycle after release.

Optional Feature:
PIPE_CTRL_PERF_EN.
- Defined: adds outputs RetireCnt[31:0] and CondFailCnt[31:0].
  - RetireCnt increments on each edge where W holds a valid, executed instruction.
  - CondFailCnt increments on each edge where E is valid and CondExE=0.
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined: these ports and the counter logic do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-stream: issue 0xE2821003 (ADD R1,R2,#3), assert reset for 1 cycle → every output and FlagsOut read 0 at once; RegWriteW never asserts for that instruction.
- ADD immediate: 0xE2821003, MEM_LAT=1 → next cycle ALUControlE=0000, ALUSrcE=1; RegWriteW=1 and MemtoRegW=0 exactly 3 edges after issue; FlagsOut unchanged.
- Flag set then branch: 0xE2522001 (SUBS R2,R2,#1) with ALUFlagsE=0100, then 0x0A000002 (BEQ) → FlagsOut=0100 and BranchTakenE=1. Repeat with ALUFlagsE=0000 → BranchTakenE=0; PCWrPendingF=1 only while BEQ is in D, E or M.
- Store: 0xE5801000 (STR R1,[R0]) → RegSrcD=10, ImmSrcD=01; MemWriteM=1 for one cycle; RegWriteW=0.
- Flush: FlushE=1 while 0xE2821003 is in D → E is a bubble; RegWriteW stays 0; with the feature enabled, RetireCnt does not change.
- Condition fail and never: 0x12821003 (ADDNE) with Z=1 → no RegWriteW; CondFailCnt +1. 0xF2821003 (cond 1111) → never executes.
